// File: rtl/alu_pkg.sv
// alu_pkg: shared widths, opcodes and instruction layout for the ALU issue/writeback stage.
// LDI's imm8 occupies [7:0] and so shares bit 7 with the rd field.
package alu_pkg;
   localparam int NREG = 8;
   localparam int DW   = 8;
   localparam int RW   = $clog2(NREG);
   localparam int OW   = 6;
   localparam int IW   = 16;

   localparam logic [OW-1:0] OP_ADD = 6'b000000;
   localparam logic [OW-1:0] OP_SUB = 6'b000001;
   localparam logic [OW-1:0] OP_INC = 6'b010000;
   localparam logic [OW-1:0] OP_DEC = 6'b010001;
   localparam logic [OW-1:0] OP_AND = 6'b100000;
   localparam logic [OW-1:0] OP_OR  = 6'b100001;
   localparam logic [OW-1:0] OP_XOR = 6'b100010;
   localparam logic [OW-1:0] OP_NOT = 6'b010010;
   localparam logic [OW-1:0] OP_SHR = 6'b001000;
   localparam logic [OW-1:0] OP_SHL = 6'b001001;
   localparam logic [OW-1:0] OP_ROR = 6'b001010;
   localparam logic [OW-1:0] OP_ROL = 6'b001011;
   localparam logic [OW-1:0] OP_LDI = 6'b110000;

   typedef struct packed {
      logic [OW-1:0] opcode;
      logic [RW-1:0] rd;
      logic [RW-1:0] rs1;
      logic [RW-1:0] rs2;
      logic          rsv;
   } instr_t;

   function automatic logic [DW-1:0] imm8(instr_t i);
      return i[DW-1:0];
   endfunction
endpackage

// File: rtl/alu_issue_wb_if.sv
// alu_issue_wb_if: instruction handshake, ALU drive/return, writeback and debug-read signals.
interface alu_issue_wb_if;
   import alu_pkg::*;
   logic          in_valid;
   logic          in_ready;
   logic [IW-1:0] in_instr;
   logic [DW-1:0] alu_src1;
   logic [DW-1:0] alu_src2;
   logic [OW-1:0] alu_opcode;
   logic [DW-1:0] alu_result;
   logic          wb_valid;
   logic [RW-1:0] wb_rd;
   logic [DW-1:0] wb_data;
   logic          zero_flag;
   logic [RW-1:0] dbg_addr;
   logic [DW-1:0] dbg_data;

   modport slave (
      input  in_valid, in_instr, alu_result, dbg_addr,
      output in_ready, alu_src1, alu_src2, alu_opcode, wb_valid, wb_rd, wb_data, zero_flag, dbg_data
   );
   modport master (
      output in_valid, in_instr, alu_result, dbg_addr,
      input  in_ready, alu_src1, alu_src2, alu_opcode, wb_valid, wb_rd, wb_data, zero_flag, dbg_data
   );
endinterface

// File: rtl/mk_regfile.sv
// mk_regfile: NREG x DW register file, one synchronous write port, three asynchronous read ports.
module mk_regfile
   import alu_pkg::*;
(
   input  logic          clk,
   input  logic          rst,
   input  logic          i_we,
   input  logic [RW-1:0] i_waddr,
   input  logic [DW-1:0] i_wdata,
   input  logic [RW-1:0] i_ra1,
   input  logic [RW-1:0] i_ra2,
   input  logic [RW-1:0] i_ra3,
   output logic [DW-1:0] o_rd1,
   output logic [DW-1:0] o_rd2,
   output logic [DW-1:0] o_rd3
);
   logic [DW-1:0] r_mem [NREG];

   always_ff @(posedge clk) begin
      if (rst) r_mem <= '{default: '0};
      else if (i_we) r_mem[i_waddr] <= i_wdata;
   end

   assign o_rd1 = r_mem[i_ra1];
   assign o_rd2 = r_mem[i_ra2];
   assign o_rd3 = r_mem[i_ra3];
endmodule

// File: rtl/alu_issue_wb.sv
// alu_issue_wb: two-stage (E/W) issue and writeback around an external combinational ALU.
// ALU_ISSUE_FORWARD_EN bypasses wb_data on a read-after-write hazard; otherwise E stalls one cycle.
module alu_issue_wb
   import alu_pkg::*;
(
   input logic           clk,
   input logic           rst,
   alu_issue_wb_if.slave bus
);
   instr_t        r_e_instr;
   logic          r_e_valid;
   logic          r_w_valid;
   logic          r_zero;
   logic [RW-1:0] r_w_rd;
   logic [DW-1:0] r_w_data;
   logic [DW-1:0] w_rd1, w_rd2, w_op1, w_op2;
   logic          w_ldi, w_haz1, w_haz2, w_stall, w_adv, w_ready;

   mk_regfile u_rf (
      .clk     (clk),
      .rst     (rst),
      .i_we    (r_w_valid),
      .i_waddr (r_w_rd),
      .i_wdata (r_w_data),
      .i_ra1   (r_e_instr.rs1),
      .i_ra2   (r_e_instr.rs2),
      .i_ra3   (bus.dbg_addr),
      .o_rd1   (w_rd1),
      .o_rd2   (w_rd2),
      .o_rd3   (bus.dbg_data)
   );

   assign w_ldi  = r_e_instr.opcode == OP_LDI;
   assign w_haz1 = r_e_valid & r_w_valid & !w_ldi & (r_e_instr.rs1 == r_w_rd);
   assign w_haz2 = r_e_valid & r_w_valid & !w_ldi & (r_e_instr.rs2 == r_w_rd);

`ifdef ALU_ISSUE_FORWARD_EN
   assign w_op1   = w_haz1 ? r_w_data : w_rd1;
   assign w_op2   = w_haz2 ? r_w_data : w_rd2;
   assign w_stall = 1'b0;
`else
   // The register file only sees the W result after this edge, so wait one cycle and re-read.
   assign w_op1   = w_rd1;
   assign w_op2   = w_rd2;
   assign w_stall = w_haz1 | w_haz2;
`endif

   assign w_adv   = r_e_valid & !w_stall;
   assign w_ready = !r_e_valid | w_adv;

   assign bus.in_ready   = w_ready;
   assign bus.alu_src1   = r_e_valid ? w_op1 : '0;
   assign bus.alu_src2   = r_e_valid ? w_op2 : '0;
   assign bus.alu_opcode = r_e_valid ? r_e_instr.opcode : '0;
   assign bus.wb_valid   = r_w_valid;
   assign bus.wb_rd      = r_w_rd;
   assign bus.wb_data    = r_w_data;
   assign bus.zero_flag  = r_zero;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_e_valid <= 1'b0;
         r_e_instr <= '0;
         r_w_valid <= 1'b0;
         r_w_rd    <= '0;
         r_w_data  <= '0;
         r_zero    <= 1'b0;
      end else begin
         if (w_ready) r_e_valid <= bus.in_valid;
         if (w_ready & bus.in_valid) r_e_instr <= bus.in_instr;
         r_w_valid <= w_adv;
         if (w_adv) begin
            r_w_rd   <= r_e_instr.rd;
            r_w_data <= w_ldi ? imm8(r_e_instr) : bus.alu_result;
         end
         if (r_w_valid) r_zero <= r_w_data == '0;
      end
   end
endmodule
